// File: rtl/glitch_pkg.sv
// Shared definitions for the glitch capture path: FSM state encoding and default sizes.
// Latency: n/a (constants only).
// Backpressure: n/a.
package glitch_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_TRIG = 3'd1;
    localparam logic [2:0] ST_HOLDOFF   = 3'd2;
    localparam logic [2:0] ST_CAPTURE   = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

    localparam int SLOTS_DEF     = 32;
    localparam int HOLDOFF_W_DEF = 32;
    localparam int TGT_W_DEF     = 12;

endpackage

// File: rtl/trig_edge_counter.sv
// Trigger synchroniser + rising-edge detector + saturating edge counter.
// Latency: a rising i_trigger shows up in edge_cnt 3 clk edges later.
// Backpressure: none; sub-cycle pulses may be missed, armed low clears everything synchronously.
//
// Ports: clk, rst (async active-high), armed (low = synchronous clear),
//        i_trigger (async input), edge_cnt (rising edges since arming, saturates at all-ones).
module trig_edge_counter #(
    parameter int TGT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             armed,
    input  logic             i_trigger,
    output logic [TGT_W-1:0] edge_cnt
);

    logic sync1;
    logic sync2;
    logic prev;
    logic rise;

    assign rise = sync2 & ~prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            prev     <= 1'b0;
            edge_cnt <= '0;
        end else if (!armed) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            prev     <= 1'b0;
            edge_cnt <= '0;
        end else begin
            sync1 <= i_trigger;
            sync2 <= sync1;
            prev  <= sync2;
            // Hold at all-ones so late edges in DONE cannot wrap back to a small count.
            if (rise && (edge_cnt != '1)) begin
                edge_cnt <= edge_cnt + TGT_W'(1);
            end
        end
    end

endmodule

// File: rtl/glitch_capture.sv
// Arms on a trigger edge count, waits holdoff, then samples a 2-bit line for SLOTS cycles into pattern.
// Latency: HOLDOFF lasts holdoff+1 clk, CAPTURE exactly SLOTS clk; rdy registered on DONE entry.
// Backpressure: none; armed low aborts to IDLE next clk, host reads pattern while rdy is high.
//
// Ports: clk, rst (async active-high), armed, i_trigger, i_sense[0:1] (bit 0 -> even pattern bits,
//        bit 1 -> odd), holdoff, pulse_target, pattern, edge_cnt, busy (HOLDOFF/CAPTURE), rdy (DONE).
// Optional macro CAPTURE_SENSE_SYNC_EN: adds a 2-FF synchroniser on i_sense (+2 clk sample latency).
module glitch_capture
    import glitch_pkg::*;
#(
    parameter int SLOTS     = SLOTS_DEF,
    parameter int HOLDOFF_W = HOLDOFF_W_DEF,
    parameter int TGT_W     = TGT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 armed,
    input  logic                 i_trigger,
    input  logic [0:1]           i_sense,
    input  logic [HOLDOFF_W-1:0] holdoff,
    input  logic [TGT_W-1:0]     pulse_target,
    output logic [2*SLOTS-1:0]   pattern,
    output logic [TGT_W-1:0]     edge_cnt,
    output logic                 busy,
    output logic                 rdy
);

    localparam int              SLOT_W    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);

    logic [2:0]           state;
    logic [2:0]           state_nxt;
    logic [HOLDOFF_W-1:0] ho_cnt;
    logic [SLOT_W-1:0]    slot;
    logic [1:0]           smp;      // {odd bit, even bit} for the current slot

    trig_edge_counter #(
        .TGT_W (TGT_W)
    ) u_trig (
        .clk       (clk),
        .rst       (rst),
        .armed     (armed),
        .i_trigger (i_trigger),
        .edge_cnt  (edge_cnt)
    );

`ifdef CAPTURE_SENSE_SYNC_EN
    logic [1:0] sense_s1;
    logic [1:0] sense_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sense_s1 <= 2'b00;
            sense_s2 <= 2'b00;
        end else begin
            sense_s1 <= {i_sense[1], i_sense[0]};
            sense_s2 <= sense_s1;
        end
    end

    assign smp = sense_s2;
`else
    assign smp = {i_sense[1], i_sense[0]};
`endif

    always_comb begin
        state_nxt = state;
        if (!armed) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:      state_nxt = ST_WAIT_TRIG;
                ST_WAIT_TRIG: if (edge_cnt == pulse_target) state_nxt = ST_HOLDOFF;
                ST_HOLDOFF:   if (ho_cnt == holdoff)        state_nxt = ST_CAPTURE;
                ST_CAPTURE:   if (slot == LAST_SLOT)        state_nxt = ST_DONE;
                ST_DONE:      state_nxt = ST_DONE;
                default:      state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            ho_cnt  <= '0;
            slot    <= '0;
            busy    <= 1'b0;
            rdy     <= 1'b0;
            pattern <= '0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == ST_HOLDOFF) || (state_nxt == ST_CAPTURE);
            rdy   <= (state_nxt == ST_DONE);

            // The write is not gated by armed: a slot being sampled when armed drops still lands.
            if (state == ST_CAPTURE) begin
                pattern[{slot, 1'b0} +: 2] <= smp;
            end

            if (!armed) begin
                ho_cnt <= '0;
                slot   <= '0;
            end else begin
                case (state)
                    ST_WAIT_TRIG: ho_cnt <= '0;
                    ST_HOLDOFF: begin
                        if (ho_cnt == holdoff) slot   <= '0;
                        else                   ho_cnt <= ho_cnt + HOLDOFF_W'(1);
                    end
                    ST_CAPTURE:   slot <= slot + SLOT_W'(1);
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_glitch_capture.sv
// Self-checking bench for glitch_capture: per-edge stimulus tables, window-based reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_glitch_capture;

    localparam int SLOTS   = 32;
    localparam int PW      = 2 * SLOTS;
    localparam int CNT_MAX = 4095;
    localparam int MAXN    = 8300;
`ifdef CAPTURE_SENSE_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          armed;
    logic          i_trigger;
    logic [0:1]    i_sense;
    logic [31:0]   ho;
    logic [11:0]   tgt;
    logic [PW-1:0] pattern;
    logic [11:0]   edge_cnt;
    logic          busy;
    logic          rdy;

    always #5 clk = ~clk;

    glitch_capture dut (
        .clk          (clk),
        .rst          (rst),
        .armed        (armed),
        .i_trigger    (i_trigger),
        .i_sense      (i_sense),
        .holdoff      (ho),
        .pulse_target (tgt),
        .pattern      (pattern),
        .edge_cnt     (edge_cnt),
        .busy         (busy),
        .rdy          (rdy)
    );

    // Stimulus tables: value applied before clk edge n (index 0 = state right after reset).
    bit       arm_v   [0:MAXN];
    bit       trig_v  [0:MAXN];
    bit [1:0] sense_v [0:MAXN];   // [0] -> i_sense[0], [1] -> i_sense[1]

    // Expected / observed values after clk edge n.
    bit            exp_busy [0:MAXN];
    bit            exp_rdy  [0:MAXN];
    int            exp_cnt  [0:MAXN];
    logic [PW-1:0] exp_pat;
    bit            obs_busy [0:MAXN];
    bit            obs_rdy  [0:MAXN];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic fill_default(input int n_edges);
        arm_v[0] = 1'b0; trig_v[0] = 1'b0; sense_v[0] = 2'b00;
        for (int n = 1; n <= n_edges; n++) begin
            arm_v[n]   = 1'b1;
            trig_v[n]  = 1'b0;
            sense_v[n] = 2'($urandom_range(0, 3));
        end
    endtask

    // Reference model. Edge count: a trigger rise applied before edge r is counted from edge r+2
    // on, unless armed was low at any edge in [r, n]. Each arming episode then finds the edge where
    // the count first equals the target, and busy / rdy / sample edges follow as windows.
    task automatic build_model(input int n_edges);
        int d_last;
        int r;
        int n;
        int a;
        int k;
        int h;
        int c0;
        int e;
        int src;
        bit [1:0] sv;
        d_last     = 0;
        exp_cnt[0] = 0;
        exp_pat    = '0;
        for (int m = 1; m <= n_edges; m++) begin
            exp_busy[m] = 1'b0;
            exp_rdy[m]  = 1'b0;
            r = m - 2;
            if (!arm_v[m]) begin
                d_last     = m;
                exp_cnt[m] = 0;
            end else begin
                exp_cnt[m] = exp_cnt[m-1];
                if (r >= 1 && r > d_last && trig_v[r] && (!trig_v[r-1] || !arm_v[r-1])
                    && exp_cnt[m] < CNT_MAX)
                    exp_cnt[m] = exp_cnt[m] + 1;
            end
        end
        n = 1;
        while (n <= n_edges) begin
            if (!arm_v[n]) begin
                n++;
                continue;
            end
            a = n;
            k = a + 1;
            while (k <= n_edges && arm_v[k]) k++;
            h = 0;
            for (int m = a + 1; m < k; m++) begin
                if (exp_cnt[m-1] == int'(tgt)) begin
                    h = m;
                    break;
                end
            end
            if (h != 0) begin
                c0 = h + int'(ho) + 2;   // first sampling edge
                for (int m = h; m < k && m <= c0 + SLOTS - 2 && m <= n_edges; m++) exp_busy[m] = 1'b1;
                for (int m = c0 + SLOTS - 1; m < k && m <= n_edges; m++) exp_rdy[m] = 1'b1;
                for (int j = 0; j < SLOTS; j++) begin
                    e = c0 + j;
                    if (e > k || e > n_edges) break;
                    src = e - LAT;
                    sv  = (src >= 1) ? sense_v[src] : 2'b00;
                    exp_pat[2*j]   = sv[0];
                    exp_pat[2*j+1] = sv[1];
                end
            end
            n = k + 1;
        end
    endtask

    task automatic run_scn(input int n_edges, input string name);
        build_model(n_edges);
        @(negedge clk);
        rst = 1'b1; armed = arm_v[1]; i_trigger = 1'b0; i_sense = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int n = 1; n <= n_edges; n++) begin
            armed      = arm_v[n];
            i_trigger  = trig_v[n];
            i_sense[0] = sense_v[n][0];
            i_sense[1] = sense_v[n][1];
            @(posedge clk);
            @(negedge clk);
            obs_busy[n] = busy;
            obs_rdy[n]  = rdy;
            chk($sformatf("%s busy@%0d", name, n), 64'(busy), 64'(exp_busy[n]));
            chk($sformatf("%s rdy@%0d", name, n), 64'(rdy), 64'(exp_rdy[n]));
            chk($sformatf("%s edge_cnt@%0d", name, n), 64'(edge_cnt), 64'(exp_cnt[n]));
        end
        chk({name, " pattern"}, pattern, exp_pat);
    endtask

    initial begin
        int            kk;
        int            st;
        int            ln;
        bit            lvl;
        logic [4:0]    k5;
        logic [PW-1:0] pv;

        rst = 1'b1; armed = 1'b0; i_trigger = 1'b0; i_sense = 2'b00; ho = '0; tgt = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset rdy", 64'(rdy), 64'd0);
        chk("reset edge_cnt", 64'(edge_cnt), 64'd0);
        chk("reset pattern", pattern, 64'd0);

        // Target 3, holdoff 5, three 4-cycle trigger pulses.
        tgt = 12'd3; ho = 32'd5;
        fill_default(80);
        for (int n = 3; n <= 6; n++)   trig_v[n] = 1'b1;
        for (int n = 11; n <= 14; n++) trig_v[n] = 1'b1;
        for (int n = 19; n <= 22; n++) trig_v[n] = 1'b1;
        run_scn(80, "t3h5");
        chk("t3h5 busy before 3rd count", 64'(obs_busy[21]), 64'd0);
        chk("t3h5 busy after 3rd count", 64'(obs_busy[22]), 64'd1);
        chk("t3h5 rdy edge 59", 64'(obs_rdy[59]), 64'd0);
        chk("t3h5 rdy edge 60", 64'(obs_rdy[60]), 64'd1);
        chk("t3h5 final edge_cnt", 64'(edge_cnt), 64'd3);

        // Target 0, holdoff 0: rdy first seen after the 35th edge.
        tgt = 12'd0; ho = 32'd0;
        fill_default(40);
        run_scn(40, "t0h0");
        chk("t0h0 rdy edge 34", 64'(obs_rdy[34]), 64'd0);
        chk("t0h0 rdy edge 35", 64'(obs_rdy[35]), 64'd1);

        // Reset asserted while slot 10 is the latest slot written.
        fill_default(14);
        run_scn(14, "midcap");
        @(negedge clk);
        rst = 1'b1; armed = 1'b1;
        #1;
        chk("midcap rst busy", 64'(busy), 64'd0);
        chk("midcap rst rdy", 64'(rdy), 64'd0);
        chk("midcap rst edge_cnt", 64'(edge_cnt), 64'd0);
        chk("midcap rst pattern", pattern, 64'd0);

        // Loopback map after restart: slot k carries {i_sense[0], i_sense[1]} = {k[0], k[1]}.
        tgt = 12'd0; ho = 32'd3;
        fill_default(45);
        for (int n = 1; n <= 45; n++) begin
            kk = n + LAT - 7;
            if (kk >= 0 && kk < SLOTS) sense_v[n] = kk[1:0];
        end
        run_scn(45, "loop");
        pv = pattern;
        for (int k = 0; k < SLOTS; k++) begin
            k5 = 5'(k);
            chk($sformatf("loop bits of slot %0d", k), 64'({pv[2*k+1], pv[2*k]}), 64'({k5[1], k5[0]}));
        end
        chk("loop rdy", 64'(rdy), 64'd1);

        // Step on i_sense at capture slot 5.
        tgt = 12'd0; ho = 32'd1;
        fill_default(40);
        for (int n = 1; n <= 40; n++) sense_v[n] = (n >= 10) ? 2'b11 : 2'b00;
        run_scn(40, "step");
        pv = pattern;
        chk("step slot before first", 64'({pv[2*(4+LAT)+1], pv[2*(4+LAT)]}), 64'd0);
        chk("step slot first", 64'({pv[2*(5+LAT)+1], pv[2*(5+LAT)]}), 64'd3);

        // Full capture, then re-arm and drop armed at slot 20 of the second capture.
        tgt = 12'd0; ho = 32'd2;
        fill_default(95);
        arm_v[61] = 1'b0; arm_v[62] = 1'b0;
        for (int n = 63; n <= 92; n++) sense_v[n] = ~sense_v[n-62];
        for (int n = 88; n <= 95; n++) arm_v[n] = 1'b0;
        run_scn(95, "drop");
        kk = 0;
        for (int n = 63; n <= 95; n++) kk += int'(obs_rdy[n]);
        chk("drop rdy stays low", 64'(kk), 64'd0);

        // Saturation: 4100 one-cycle trigger pulses, target 4095.
        tgt = 12'd4095; ho = 32'd0;
        fill_default(8240);
        for (int n = 2; n <= 8200; n += 2) trig_v[n] = 1'b1;
        run_scn(8240, "sat");
        chk("sat edge_cnt", 64'(edge_cnt), 64'd4095);
        chk("sat rdy", 64'(rdy), 64'd1);

        // Random trigger waveforms, targets, holdoffs and abort windows.
        for (int s = 0; s < 4; s++) begin
            tgt = 12'($urandom_range(0, 3));
            ho  = 32'($urandom_range(0, 6));
            fill_default(160);
            lvl = 1'b0;
            for (int n = 1; n <= 160; n++) begin
                if ($urandom_range(0, 2) == 0) lvl = ~lvl;
                trig_v[n] = lvl;
            end
            for (int w = 0; w < 2; w++) begin
                st = $urandom_range(20, 150);
                ln = $urandom_range(1, 3);
                for (int n = st; n < st + ln; n++) arm_v[n] = 1'b0;
            end
            run_scn(160, $sformatf("rand%0d", s));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
